// File: rtl/fp_converter_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_converter_seq
// Purpose  : Sequential linear-to-floating-point converter. A two's-complement
//            sample D is accepted over a valid/ready handshake and converted
//            to sign S, exponent E and mantissa F (magnitude = F * 2^E). The
//            magnitude is normalised by a one-bit-per-cycle right shifter, so
//            no wide priority encoder is needed. Supports round-half-up or
//            truncation per sample and flags clamped results on sat.
// Ports    : clk       - rising-edge clock
//            rst_n     - synchronous active-low reset
//            D         - two's-complement sample (DATA_W)
//            in_valid  - D valid
//            in_ready  - converter idle and able to accept D
//            rnd_mode  - 0 = round half up on first dropped bit, 1 = truncate
//            S, E, F   - sign, exponent (EXP_W), mantissa (MAN_W)
//            sat       - result clamped
//            out_valid - S/E/F/sat valid
//            out_ready - consumer accepts result
// Revision : 1.0 - initial release
// ============================================================================
module fp_converter_seq #(
  parameter int DATA_W = 12,
  parameter int EXP_W  = 3,
  parameter int MAN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] D,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rnd_mode,
  output logic              S,
  output logic [EXP_W-1:0]  E,
  output logic [MAN_W-1:0]  F,
  output logic              sat,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int EMAX = (1 << EXP_W) - 1;
  // One extra bit so that e+1 == EMAX+1 is representable for the clamp test.
  localparam int EW   = $clog2(EMAX + 2);
  localparam int SW   = DATA_W - 1;

  localparam logic [EW-1:0]    C_EMAX_E   = EW'(EMAX);
  localparam logic [MAN_W-1:0] C_MAN_HALF = {1'b1, {(MAN_W-1){1'b0}}};

  if (MAN_W < 2 || DATA_W - 1 > MAN_W + EMAX) begin : g_bad_params
    $error("fp_converter_seq: illegal DATA_W/EXP_W/MAN_W combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SW-1:0]    r_sh;
  logic [EW-1:0]    r_e;
  logic             r_rbit;
  logic             r_mode;
  logic             r_sat_pend;
  logic             r_sign;
  logic             r_s;
  logic [EXP_W-1:0] r_exp;
  logic [MAN_W-1:0] r_man;
  logic             r_sat;

  // ---------------------------------------------------------------- capture
  logic          w_neg;
  logic          w_is_min;
  logic [SW-1:0] w_abs;
  logic [SW-1:0] w_mag;

  assign w_neg    = D[DATA_W-1];
  // The most negative sample has no positive counterpart in SW bits.
  assign w_is_min = w_neg & ~|D[SW-1:0];
  assign w_abs    = w_neg ? (~D[SW-1:0] + SW'(1)) : D[SW-1:0];
  assign w_mag    = w_is_min ? {SW{1'b1}} : w_abs;

  // --------------------------------------------------------------- finalise
  logic             w_need_shift;
  logic [MAN_W-1:0] w_man;
  logic             w_inc;
  logic [MAN_W:0]   w_sum;
  logic             w_carry;
  logic [EW-1:0]    w_e_fin;
  logic [MAN_W-1:0] w_f_fin;
  logic             w_ovf;

  assign w_need_shift = |(r_sh >> MAN_W);

  if (MAN_W <= SW) begin : g_man_slice
    assign w_man = r_sh[MAN_W-1:0];
  end else begin : g_man_ext
    assign w_man = {{(MAN_W-SW){1'b0}}, r_sh};
  end

  assign w_inc   = ~r_mode & r_rbit;
  assign w_sum   = {1'b0, w_man} + {{MAN_W{1'b0}}, w_inc};
  // A carry out means the mantissa was all ones: renormalise to 1000..0.
  assign w_carry = w_sum[MAN_W];
  assign w_e_fin = r_e + {{(EW-1){1'b0}}, w_carry};
  assign w_f_fin = w_carry ? C_MAN_HALF : w_sum[MAN_W-1:0];
  assign w_ovf   = (w_e_fin > C_EMAX_E);

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)      w_state_nxt = ST_NORM;
      ST_NORM: if (!w_need_shift) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)     w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh       <= '0;
      r_e        <= '0;
      r_rbit     <= 1'b0;
      r_mode     <= 1'b0;
      r_sat_pend <= 1'b0;
      r_sign     <= 1'b0;
      r_s        <= 1'b0;
      r_exp      <= '0;
      r_man      <= '0;
      r_sat      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign     <= w_neg;
            r_mode     <= rnd_mode;
            r_sh       <= w_mag;
            r_e        <= '0;
            r_rbit     <= 1'b0;
            r_sat_pend <= w_is_min;
          end
        end
        ST_NORM: begin
          if (w_need_shift) begin
            r_rbit <= r_sh[0];
            r_sh   <= r_sh >> 1;
            r_e    <= r_e + EW'(1);
          end else begin
            // Result registers only change here, so no partial value is
            // ever visible and the last result persists after handoff.
            r_s <= r_sign;
            if (w_ovf) begin
              r_exp <= {EXP_W{1'b1}};
              r_man <= {MAN_W{1'b1}};
              r_sat <= 1'b1;
            end else begin
              r_exp <= w_e_fin[EXP_W-1:0];
              r_man <= w_f_fin;
              r_sat <= r_sat_pend;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign S         = r_s;
  assign E         = r_exp;
  assign F         = r_man;
  assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_fp_converter_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_converter_seq
// Purpose  : Directed self-checking bench for fp_converter_seq. Drives a
//            default-parameter instance and a DATA_W=16/EXP_W=4/MAN_W=6
//            instance with hand-computed vectors, backpressure and a reset
//            issued in the middle of normalisation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_converter_seq;

  logic clk;
  logic rst_n;

  // default instance
  logic [11:0] d12;
  logic        vin12, rdy12, rnd12, s12, sat12, ov12, ordy12;
  logic [2:0]  e12;
  logic [3:0]  f12;

  // wide instance
  logic [15:0] d16;
  logic        vin16, rdy16, rnd16, s16, sat16, ov16, ordy16;
  logic [3:0]  e16;
  logic [5:0]  f16;

  int n_total;
  int n_bad;

  fp_converter_seq dut (
    .clk(clk), .rst_n(rst_n), .D(d12), .in_valid(vin12), .in_ready(rdy12),
    .rnd_mode(rnd12), .S(s12), .E(e12), .F(f12), .sat(sat12),
    .out_valid(ov12), .out_ready(ordy12)
  );

  fp_converter_seq #(.DATA_W(16), .EXP_W(4), .MAN_W(6)) dut16 (
    .clk(clk), .rst_n(rst_n), .D(d16), .in_valid(vin16), .in_ready(rdy16),
    .rnd_mode(rnd16), .S(s16), .E(e16), .F(f16), .sat(sat16),
    .out_valid(ov16), .out_ready(ordy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept one sample, measure latency and check the result.
  task automatic run_conv(input bit wide, input string tag, input int d,
                          input logic mode, input logic es, input int ee,
                          input int ef, input logic esat, input int elat);
    int lat;
    logic got;
    @(negedge clk);
    chk({tag, "_in_ready"}, wide ? rdy16 : rdy12, 1);
    if (wide) begin d16 = d[15:0]; rnd16 = mode; vin16 = 1'b1; end
    else      begin d12 = d[11:0]; rnd12 = mode; vin12 = 1'b1; end
    @(posedge clk); #1;
    vin12 = 1'b0; vin16 = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      got = wide ? ov16 : ov12;
    end
    chk({tag, "_valid"}, got, 1);
    chk({tag, "_lat"},   lat, elat);
    chk({tag, "_S"},     wide ? s16 : s12, es);
    chk({tag, "_E"},     wide ? 32'(e16) : 32'(e12), ee);
    chk({tag, "_F"},     wide ? 32'(f16) : 32'(f12), ef);
    chk({tag, "_sat"},   wide ? sat16 : sat12, esat);
    @(posedge clk); #1;
    chk({tag, "_drop"},  wide ? ov16 : ov12, 0);
  endtask

  initial begin
    int lat;
    int seen;
    n_total = 0; n_bad = 0;
    rst_n = 1'b0;
    d12 = '0; vin12 = 1'b0; rnd12 = 1'b0; ordy12 = 1'b1;
    d16 = '0; vin16 = 1'b0; rnd16 = 1'b0; ordy16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_S", s12, 0);
    chk("rst_E", e12, 0);
    chk("rst_F", f12, 0);
    chk("rst_sat", sat12, 0);
    chk("rst_out_valid", ov12, 0);
    chk("rst_in_ready", rdy12, 1);
    @(negedge clk); rst_n = 1'b1;

    //          wide tag        D      mode S  E  F   sat lat
    run_conv(0, "m40",      -40,   0,   1, 2, 10, 0,  3);
    run_conv(0, "zero",     0,     0,   0, 0, 0,  0,  1);
    run_conv(0, "p125r",    125,   0,   0, 4, 8,  0,  4);
    run_conv(0, "p125t",    125,   1,   0, 3, 15, 0,  4);
    run_conv(0, "p56",      56,    0,   0, 2, 14, 0,  3);
    run_conv(0, "p422",     422,   0,   0, 5, 13, 0,  6);
    run_conv(0, "p15",      15,    0,   0, 0, 15, 0,  1);
    run_conv(0, "p16",      16,    0,   0, 1, 8,  0,  2);
    run_conv(0, "m1",       -1,    0,   1, 0, 1,  0,  1);
    run_conv(0, "min",      -2048, 0,   1, 7, 15, 1,  8);
    run_conv(0, "max_r",    2047,  0,   0, 7, 15, 1,  8);
    run_conv(0, "max_t",    2047,  1,   0, 7, 15, 0,  8);
    run_conv(1, "w_min_t",  -32768, 1,  1, 9, 63, 1,  10);
    run_conv(1, "w_min_r",  -32768, 0,  1, 10, 32, 1, 10);

    // Backpressure: result held in DONE while a new sample waits.
    @(negedge clk);
    ordy12 = 1'b0; d12 = 12'd56; rnd12 = 1'b0; vin12 = 1'b1;
    @(posedge clk); #1;
    d12 = 12'd15;
    lat = 0;
    while (!ov12 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_valid", ov12, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", ov12, 1);
      chk("bp_hold_E", e12, 2);
      chk("bp_hold_F", f12, 14);
      chk("bp_hold_in_ready", rdy12, 0);
    end
    @(negedge clk); ordy12 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", ov12, 0);
    chk("bp_release_in_ready", rdy12, 1);
    @(posedge clk); #1;
    vin12 = 1'b0;
    chk("bp_accept_in_ready", rdy12, 0);
    @(posedge clk); #1;
    chk("bp_new_valid", ov12, 1);
    chk("bp_new_E", e12, 0);
    chk("bp_new_F", f12, 15);
    @(posedge clk); #1;

    // Reset in the middle of normalisation aborts the conversion.
    @(negedge clk);
    d12 = 12'd2047; rnd12 = 1'b0; vin12 = 1'b1;
    @(posedge clk); #1;
    vin12 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", ov12, 0);
    chk("mid_rst_S", s12, 0);
    chk("mid_rst_E", e12, 0);
    chk("mid_rst_F", f12, 0);
    chk("mid_rst_sat", sat12, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", rdy12, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov12) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_converter_seq.md
Name: fp_converter_seq

Overview:
Parametrised, sequential successor to the combinational 12-bit linear-to-floating-point converter. Accepts a two's-complement sample D over a valid/ready handshake and produces sign S, exponent E and mantissa F, where the represented magnitude is F * 2^E. Normalisation uses an iterative one-bit-per-cycle shifter FSM, so the block adds no wide priority encoder. Adds selectable rounding mode and a saturation flag; sits between the sample source and the compressed-sample consumer.

Parameters:
DATA_W, 12, input width (two's complement)
EXP_W, 3, exponent width; EMAX = 2^EXP_W - 1
MAN_W, 4, mantissa width (no hidden bit)
Legal only if MAN_W >= 2 and DATA_W-1 <= MAN_W + EMAX; elaboration error otherwise.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
D  in  DATA_W  two's-complement sample
in_valid  in  1  D valid
in_ready  out  1  converter can accept D
rnd_mode  in  1  sampled with D: 0 = round-half-up on first dropped bit, 1 = truncate
S  out  1  sign
E  out  EXP_W  exponent
F  out  MAN_W  mantissa
sat  out  1  result clamped
out_valid  out  1  S/E/F/sat valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; S=0, E=0, F=0, sat=0, out_valid=0, in_ready=1. Reset in any state aborts the in-flight conversion; no partial result is ever presented.
- States IDLE, NORM, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE: on in_valid&in_ready, capture S=D[DATA_W-1], mode, mag=|D| into shift register sh (DATA_W-1 bits), e=0, rbit=0, sat_pend=0. For D=-2^(DATA_W-1), mag=2^(DATA_W-1)-1 and sat_pend=1. Next state NORM.
- NORM, each cycle: if sh >= 2^MAN_W, then rbit<=sh[0], sh<=sh>>1, e<=e+1, stay in NORM. Otherwise finalise and go to DONE:
  - F=sh[MAN_W-1:0] and E=e.
  - If mode=0 and rbit=1, add 1 to F.
  - If the increment carries out (F was all ones), set F=2^(MAN_W-1) and E=e+1.
  - If E would exceed EMAX, set E=EMAX, F=all ones, sat=1.
  - sat is also 1 if sat_pend=1.
- Latency: for an accept at edge k, out_valid rises after edge k+e+1, where e = max(0, bitlen(mag)-MAN_W). Minimum 1 cycle; maximum EMAX+1 cycles (8 at defaults).
- DONE: S/E/F/sat held stable while out_ready=0. On out_ready=1, go to IDLE; out_valid drops the next cycle and outputs keep their last value. No accept occurs in the same cycle as the result handoff, so peak throughput is one sample per latency+2 cycles.
- D and rnd_mode are ignored outside the accept cycle. in_valid while busy is not an error; the source holds it.
- Zero input gives S=0, E=0, F=0, sat=0, latency 1.
- The e counter needs ceil(log2(EMAX+2)) bits so the EMAX+1 overflow check is exact.

Test Plan:
- Defaults, rnd_mode=0, out_ready=1. D=-40 -> S=1 E=2 F=10 sat=0, out_valid 3 cycles after accept. D=0 -> 0/0/0, 1 cycle.
- D=125, rnd_mode=0 -> S=0 E=4 F=8 (mantissa carry renormalises). Same D with rnd_mode=1 -> E=3 F=15.
- D=56 -> E=2 F=14. D=422 -> E=5 F=13. D=15 -> E=0 F=15, latency 1.
- D=-2048 -> S=1 E=7 F=15 sat=1. D=2047 -> E=7 F=15 sat=1 (round overflow clamp). D=2047 with rnd_mode=1 -> E=7 F=15 sat=0. Each has latency 8.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout, with a new D presented and not accepted. Release -> IDLE, then the new D is accepted.
- Reset mid-NORM: D=2047 accepted, rst_n=0 at cycle 3 -> out_valid never asserts, all outputs 0, in_ready=1 the cycle after reset. Also run DATA_W=16, EXP_W=4, MAN_W=6 with D=-32768 -> E=9 F=63 sat=1.
